// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: the pipeline WB stage always wins, buffered multi-cycle results drain in idle slots.
// Optional per-register pending mask for the hazard unit is enabled by defining WB_ARB_SCOREBOARD_EN.
module wb_port_arbiter #(
  parameter int WIDTH        = 64,
  parameter int ADDR         = 5,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     p_Clk,
  input  logic                     p_Reset,
  input  logic                     p_WB_RegWrite,
  input  logic [ADDR-1:0]          p_WB_RegDest,
  input  logic [WIDTH-1:0]         p_WB_Data,
  input  logic                     p_MC_Valid,
  output logic                     p_MC_Ready,
  input  logic [ADDR-1:0]          p_MC_RegDest,
  input  logic [WIDTH-1:0]         p_MC_Data,
  output logic                     p_RF_WriteEn,
  output logic [ADDR-1:0]          p_RF_WriteAddr,
  output logic [WIDTH-1:0]         p_RF_WriteData,
  output logic                     p_PipeStall,
  output logic [$clog2(DEPTH):0]   p_FifoCount
`ifdef WB_ARB_SCOREBOARD_EN
  ,
  output logic [2**ADDR-1:0]       p_MC_PendingMask
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_PIPE,
    GRANT_FIFO
  } grant_e;

  logic [ADDR-1:0]  dest_mem [DEPTH];
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [SW-1:0]    starve_cnt;
  logic [SW-1:0]    starve_next;
  logic [ADDR-1:0]  head_dest;
  logic [WIDTH-1:0] head_data;
  logic             slot_busy;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  grant_e           grant;

  assign head_dest   = dest_mem[rd_ptr];
  assign head_data   = data_mem[rd_ptr];
  assign p_FifoCount = count;

  // Ready looks only at the registered count, so a same-cycle pop never frees a slot early.
  always_comb begin
    slot_busy  = p_WB_RegWrite && (p_WB_RegDest != '0);
    fifo_empty = (count == '0);
    p_MC_Ready = !p_Reset && (count < FULL_COUNT);
    push       = p_MC_Valid && p_MC_Ready && (p_MC_RegDest != '0);
  end

  always_comb begin
    grant = GRANT_NONE;
    if (slot_busy) begin
      grant = GRANT_PIPE;
    end else if (!fifo_empty) begin
      grant = GRANT_FIFO;
    end
    pop = (grant == GRANT_FIFO);
  end

  always_comb begin
    starve_next = starve_cnt;
    if (pop || fifo_empty) begin
      starve_next = '0;
    end else if (starve_cnt < STARVE_MAX) begin
      starve_next = starve_cnt + SW'(1);
    end
  end

  // Storage carries no reset; occupancy and pointers alone define which entries are live.
  always_ff @(posedge p_Clk) begin
    if (push) begin
      dest_mem[wr_ptr] <= p_MC_RegDest;
      data_mem[wr_ptr] <= p_MC_Data;
    end
  end

  always_ff @(posedge p_Clk) begin
    if (p_Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge p_Clk) begin
    if (p_Reset) begin
      p_RF_WriteEn   <= 1'b0;
      p_RF_WriteAddr <= '0;
      p_RF_WriteData <= '0;
    end else begin
      case (grant)
        GRANT_PIPE: begin
          p_RF_WriteEn   <= 1'b1;
          p_RF_WriteAddr <= p_WB_RegDest;
          p_RF_WriteData <= p_WB_Data;
        end
        GRANT_FIFO: begin
          p_RF_WriteEn   <= 1'b1;
          p_RF_WriteAddr <= head_dest;
          p_RF_WriteData <= head_data;
        end
        default: begin
          p_RF_WriteEn <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge p_Clk) begin
    if (p_Reset) begin
      starve_cnt  <= '0;
      p_PipeStall <= 1'b0;
    end else begin
      starve_cnt  <= starve_next;
      p_PipeStall <= (starve_next >= STARVE_MAX);
    end
  end

`ifdef WB_ARB_SCOREBOARD_EN
  localparam int NREG = 2**ADDR;

  // A count per register lets duplicate targets keep the bit set until the last one drains.
  logic [CW-1:0] pend_cnt  [NREG];
  logic [CW-1:0] pend_next [NREG];

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      pend_next[r] = pend_cnt[r];
      if (push && (p_MC_RegDest == ADDR'(r))) begin
        pend_next[r] = pend_next[r] + CW'(1);
      end
      if (pop && (head_dest == ADDR'(r))) begin
        pend_next[r] = pend_next[r] - CW'(1);
      end
    end
  end

  always_ff @(posedge p_Clk) begin
    if (p_Reset) begin
      for (int r = 0; r < NREG; r++) begin
        pend_cnt[r] <= '0;
      end
      p_MC_PendingMask <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        pend_cnt[r]         <= pend_next[r];
        p_MC_PendingMask[r] <= (pend_next[r] != '0);
      end
    end
  end
`endif

endmodule
